// File: rtl/result_display_seq_pkg.sv
// Shared widths, FSM encoding and the double-dabble step used by the
// result display sequencer and its BCD converter.
package conv_pkg;
    localparam int RES_W   = 8;
    localparam int BCD_W   = 12;
    localparam int DWELL_W = 24;
    localparam int NUM_RES = 4;
    localparam int SH_W    = BCD_W + RES_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    // One shift-add-3 iteration over {bcd, bin}: bump digits >= 5, then shift left.
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
        logic [SH_W-1:0] t;
        t = sh;
        for (int d = 0; d < BCD_W/4; d++) begin
            if (t[RES_W+4*d +: 4] >= 4'd5)
                t[RES_W+4*d +: 4] = t[RES_W+4*d +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/result_display_seq_if.sv
// Control/data bundle between the convolution controller and the display sequencer.
interface result_display_seq_if;
    import conv_pkg::*;

    logic             load;
    logic             abort;
    logic [RES_W-1:0] res_11;
    logic [RES_W-1:0] res_12;
    logic [RES_W-1:0] res_21;
    logic [RES_W-1:0] res_22;
    logic             busy;
    logic             disp_valid;
    logic [1:0]       disp_idx;
    logic [RES_W-1:0] disp_bin;
    logic [BCD_W-1:0] disp_bcd;
    logic             done;

    modport master (
        output load, abort, res_11, res_12, res_21, res_22,
        input  busy, disp_valid, disp_idx, disp_bin, disp_bcd, done
    );

    modport slave (
        input  load, abort, res_11, res_12, res_21, res_22,
        output busy, disp_valid, disp_idx, disp_bin, disp_bcd, done
    );
endinterface

// File: rtl/result_display_seq_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD: one setup cycle, then one
// shift-add-3 iteration per cycle; done pulses with the last iteration.
module bin2bcd_seq
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic [RES_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    logic [SH_W-1:0] r_sh;
    logic [3:0]      r_cnt;
    logic            r_busy;
    logic            r_done;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_sh   <= {{BCD_W{1'b0}}, i_bin};
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sh  <= dabble_step(r_sh);
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'(RES_W-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_sh[SH_W-1:RES_W];
endmodule

// File: rtl/result_display_seq.sv
// Captures four 2x2 convolution results and shows each in turn (binary and
// BCD) for DWELL_CYCLES cycles, optionally cycling until aborted.
module result_display_seq
    import conv_pkg::*;
#(
    parameter int DWELL_CYCLES = 16,
    parameter int REPEAT       = 0
)(
    input logic                 clk,
    input logic                 rst,
    result_display_seq_if.slave bus
);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t                         r_state;
    state_t                         w_next;
    logic [NUM_RES-1:0][RES_W-1:0]  r_res;
    logic [1:0]                     r_idx;
    logic [DWELL_W-1:0]             r_dwell;
    logic                           r_start;
    logic                           r_busy;
    logic                           r_valid;
    logic                           r_done;
    logic [1:0]                     r_disp_idx;
    logic [RES_W-1:0]               r_disp_bin;
    logic [BCD_W-1:0]               r_disp_bcd;
    logic                           w_conv_busy;
    logic                           w_conv_done;
    logic [BCD_W-1:0]               w_conv_bcd;
    logic                           w_dwell_end;

    assign w_dwell_end = (r_dwell == DWELL_LAST);

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.abort),
        .i_start (r_start & ~w_conv_busy),
        .i_bin   (r_res[r_idx]),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.load) w_next = ST_CONVERT;
            ST_CONVERT: if (w_conv_done) w_next = ST_SHOW;
            ST_SHOW: begin
                if (w_dwell_end)
                    w_next = (r_idx != 2'd3 || REPEAT != 0) ? ST_CONVERT : ST_FINISH;
            end
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (bus.abort) w_next = ST_IDLE;
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res      <= '0;
            r_idx      <= '0;
            r_dwell    <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_disp_idx <= '0;
            r_disp_bin <= '0;
            r_disp_bcd <= '0;
        end else begin
            r_start <= 1'b0;
            r_busy  <= (w_next != ST_IDLE);
            r_valid <= (w_next == ST_SHOW);
            r_done  <= (w_next == ST_FINISH);
            if (r_state == ST_IDLE && w_next == ST_CONVERT) begin
                r_res   <= {bus.res_22, bus.res_21, bus.res_12, bus.res_11};
                r_idx   <= '0;
                r_start <= 1'b1;
            end
            if (r_state == ST_CONVERT && w_next == ST_SHOW) begin
                r_disp_idx <= r_idx;
                r_disp_bin <= r_res[r_idx];
                r_disp_bcd <= w_conv_bcd;
                r_dwell    <= '0;
            end
            if (r_state == ST_SHOW) begin
                r_dwell <= r_dwell + DWELL_W'(1);
                if (w_next == ST_CONVERT) begin
                    r_idx   <= r_idx + 2'd1;
                    r_start <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.disp_valid = r_valid;
    assign bus.disp_idx   = r_disp_idx;
    assign bus.disp_bin   = r_disp_bin;
    assign bus.disp_bcd   = r_disp_bcd;
    assign bus.done       = r_done;
endmodule
